// File: rtl/accelerator_temporal_weighting.sv
// accelerator_temporal_weighting
//   Streams in a weighting matrix w(R x N) and a link matrix L(N x N) and
//   produces either the backward weighting b(i;j) = sum_g L(g;j)*w(i;g)
//   (MODE=0) or the forward weighting f(i;g) = sum_j L(g;j)*w(i;j) (MODE=1).
//   One L element is consumed per LOAD_L visit, followed by R MAC cycles,
//   one per row i. Results stream out row-major.
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   START, MODE, SIZE_R/N_IN       operation request, latched in IDLE
//   READY, ERROR                   one-cycle completion / illegal-size pulses
//   W_IN / W_IN_VALID / W_IN_READY w stream, row-major (i outer, j inner)
//   L_IN / L_IN_VALID / L_IN_READY L stream, row-major (g outer, j inner)
//   B_OUT / _VALID / _READY        result stream, row-major
//   B_OUT_J_LAST, B_OUT_LAST       end-of-row / end-of-result flags
module accelerator_temporal_weighting #(
    parameter int DATA_SIZE     = 64,
    parameter int CONTROL_SIZE  = 64,
    parameter int FRACTION_SIZE = 0,
    parameter int MAX_R         = 4,
    parameter int MAX_N         = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    output logic                 ERROR,
    input  logic                 MODE,
    input  logic [DATA_SIZE-1:0] SIZE_R_IN,
    input  logic [DATA_SIZE-1:0] SIZE_N_IN,
    input  logic [DATA_SIZE-1:0] W_IN,
    input  logic                 W_IN_VALID,
    output logic                 W_IN_READY,
    input  logic [DATA_SIZE-1:0] L_IN,
    input  logic                 L_IN_VALID,
    output logic                 L_IN_READY,
    output logic [DATA_SIZE-1:0] B_OUT,
    output logic                 B_OUT_VALID,
    input  logic                 B_OUT_READY,
    output logic                 B_OUT_J_LAST,
    output logic                 B_OUT_LAST
);

    localparam int RW = (MAX_R > 1) ? $clog2(MAX_R) : 1;
    localparam int NW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam logic [CONTROL_SIZE-1:0] ONE = CONTROL_SIZE'(1);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_L, MAC, OUTPUT} state_t;

    state_t                  state_q, state_d;
    logic [CONTROL_SIZE-1:0] r_q, r_d, n_q, n_d, i_q, i_d, j_q, j_d, g_q, g_d;
    logic                    mode_q, mode_d;
    logic [DATA_SIZE-1:0]    l_q, l_d;
    logic [DATA_SIZE-1:0]    w_q   [MAX_R][MAX_N];
    logic [DATA_SIZE-1:0]    w_d   [MAX_R][MAX_N];
    logic [DATA_SIZE-1:0]    acc_q [MAX_R][MAX_N];
    logic [DATA_SIZE-1:0]    acc_d [MAX_R][MAX_N];
    logic [DATA_SIZE-1:0]    b_out_q, b_out_d;
    logic                    b_valid_q, b_valid_d, j_last_q, j_last_d, last_q, last_d;
    logic                    ready_q, ready_d, error_q, error_d;

    logic                    size_ok, i_end, j_end, g_end;
    logic [CONTROL_SIZE-1:0] ni, nj;
    logic [DATA_SIZE-1:0]    w_sel, addend;
    logic [2*DATA_SIZE-1:0]  l_ext, w_ext;
    logic signed [2*DATA_SIZE-1:0] prod;
    logic [NW-1:0]           col;

    always_comb begin
        size_ok = (SIZE_R_IN != '0) && (SIZE_R_IN <= DATA_SIZE'(MAX_R)) &&
                  (SIZE_N_IN != '0) && (SIZE_N_IN <= DATA_SIZE'(MAX_N));
        i_end   = (i_q == r_q - ONE);
        j_end   = (j_q == n_q - ONE);
        g_end   = (g_q == n_q - ONE);

        // Backward accumulates into column j and reads w at column g;
        // forward swaps the roles of the two L indices.
        col    = mode_q ? g_q[NW-1:0] : j_q[NW-1:0];
        w_sel  = mode_q ? w_q[i_q[RW-1:0]][j_q[NW-1:0]] : w_q[i_q[RW-1:0]][g_q[NW-1:0]];
        // Sign-extend both factors so the low 2*DATA_SIZE bits of an
        // unsigned multiply equal the signed product.
        l_ext  = {{DATA_SIZE{l_q[DATA_SIZE-1]}}, l_q};
        w_ext  = {{DATA_SIZE{w_sel[DATA_SIZE-1]}}, w_sel};
        prod   = $signed(l_ext * w_ext);
        addend = DATA_SIZE'(prod >>> FRACTION_SIZE);

        // Next output position, used when a result word is accepted.
        ni = j_end ? i_q + ONE : i_q;
        nj = j_end ? '0 : j_q + ONE;

        state_d   = state_q;
        r_d       = r_q;
        n_d       = n_q;
        i_d       = i_q;
        j_d       = j_q;
        g_d       = g_q;
        mode_d    = mode_q;
        l_d       = l_q;
        w_d       = w_q;
        acc_d     = acc_q;
        b_out_d   = b_out_q;
        b_valid_d = b_valid_q;
        j_last_d  = j_last_q;
        last_d    = last_q;
        ready_d   = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            IDLE: if (START) begin
                if (size_ok) begin
                    r_d     = CONTROL_SIZE'(SIZE_R_IN);
                    n_d     = CONTROL_SIZE'(SIZE_N_IN);
                    mode_d  = MODE;
                    i_d     = '0;
                    j_d     = '0;
                    g_d     = '0;
                    acc_d   = '{default: '0};
                    state_d = LOAD_W;
                end else begin
                    error_d = 1'b1;
                end
            end
            LOAD_W: if (W_IN_VALID) begin
                w_d[i_q[RW-1:0]][j_q[NW-1:0]] = W_IN;
                if (j_end) begin
                    j_d = '0;
                    if (i_end) begin
                        i_d     = '0;
                        state_d = LOAD_L;
                    end else begin
                        i_d = i_q + ONE;
                    end
                end else begin
                    j_d = j_q + ONE;
                end
            end
            LOAD_L: if (L_IN_VALID) begin
                l_d     = L_IN;
                i_d     = '0;
                state_d = MAC;
            end
            MAC: begin
                acc_d[i_q[RW-1:0]][col] = acc_q[i_q[RW-1:0]][col] + addend;
                if (!i_end) begin
                    i_d = i_q + ONE;
                end else begin
                    i_d = '0;
                    if (!j_end) begin
                        j_d     = j_q + ONE;
                        state_d = LOAD_L;
                    end else begin
                        j_d = '0;
                        if (g_end) begin
                            g_d     = '0;
                            state_d = OUTPUT;
                        end else begin
                            g_d     = g_q + ONE;
                            state_d = LOAD_L;
                        end
                    end
                end
            end
            OUTPUT: begin
                if (!b_valid_q) begin
                    // First cycle in OUTPUT: present word (0,0).
                    b_out_d   = acc_q[i_q[RW-1:0]][j_q[NW-1:0]];
                    b_valid_d = 1'b1;
                    j_last_d  = j_end;
                    last_d    = i_end && j_end;
                end else if (B_OUT_READY) begin
                    if (last_q) begin
                        b_out_d   = '0;
                        b_valid_d = 1'b0;
                        j_last_d  = 1'b0;
                        last_d    = 1'b0;
                        i_d       = '0;
                        j_d       = '0;
                        ready_d   = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        i_d      = ni;
                        j_d      = nj;
                        b_out_d  = acc_q[ni[RW-1:0]][nj[NW-1:0]];
                        j_last_d = (nj == n_q - ONE);
                        last_d   = (ni == r_q - ONE) && (nj == n_q - ONE);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            r_q       <= '0;
            n_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            g_q       <= '0;
            mode_q    <= 1'b0;
            l_q       <= '0;
            w_q       <= '{default: '0};
            acc_q     <= '{default: '0};
            b_out_q   <= '0;
            b_valid_q <= 1'b0;
            j_last_q  <= 1'b0;
            last_q    <= 1'b0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            n_q       <= n_d;
            i_q       <= i_d;
            j_q       <= j_d;
            g_q       <= g_d;
            mode_q    <= mode_d;
            l_q       <= l_d;
            w_q       <= w_d;
            acc_q     <= acc_d;
            b_out_q   <= b_out_d;
            b_valid_q <= b_valid_d;
            j_last_q  <= j_last_d;
            last_q    <= last_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
        end
    end

    assign W_IN_READY   = (state_q == LOAD_W);
    assign L_IN_READY   = (state_q == LOAD_L);
    assign B_OUT        = b_out_q;
    assign B_OUT_VALID  = b_valid_q;
    assign B_OUT_J_LAST = j_last_q;
    assign B_OUT_LAST   = last_q;
    assign READY        = ready_q;
    assign ERROR        = error_q;

endmodule

// File: tb/tb_accelerator_temporal_weighting.sv
// Bench for accelerator_temporal_weighting: fixed vectors with hand-computed
// results, randomized vectors scored against a matrix-sum reference model,
// plus hand-written error, backpressure and mid-operation reset sequences.
module tb_accelerator_temporal_weighting;

    localparam int DS = 64;
    localparam int NV = 10;

    logic          CLK = 1'b0;
    logic          RST, START, MODE, W_IN_VALID, L_IN_VALID, B_OUT_READY;
    logic [DS-1:0] SIZE_R_IN, SIZE_N_IN, W_IN, L_IN, B_OUT;
    logic          READY, ERROR, W_IN_READY, L_IN_READY, B_OUT_VALID, B_OUT_J_LAST, B_OUT_LAST;

    accelerator_temporal_weighting #(
        .DATA_SIZE(DS), .CONTROL_SIZE(64), .FRACTION_SIZE(0), .MAX_R(4), .MAX_N(8)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .READY(READY), .ERROR(ERROR), .MODE(MODE),
        .SIZE_R_IN(SIZE_R_IN), .SIZE_N_IN(SIZE_N_IN),
        .W_IN(W_IN), .W_IN_VALID(W_IN_VALID), .W_IN_READY(W_IN_READY),
        .L_IN(L_IN), .L_IN_VALID(L_IN_VALID), .L_IN_READY(L_IN_READY),
        .B_OUT(B_OUT), .B_OUT_VALID(B_OUT_VALID), .B_OUT_READY(B_OUT_READY),
        .B_OUT_J_LAST(B_OUT_J_LAST), .B_OUT_LAST(B_OUT_LAST)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int     r;
        int     n;
        bit     mode;
        bit     gaps;
        bit     bp;
        longint w[32];
        longint l[64];
        longint e[32];
    } vec_t;

    vec_t vecs[NV];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Reference: plain matrix sums over the stored w and L.
    function automatic void fill_expect(input int v);
        longint s;
        for (int i = 0; i < vecs[v].r; i++)
            for (int c = 0; c < vecs[v].n; c++) begin
                s = 0;
                for (int k = 0; k < vecs[v].n; k++)
                    if (!vecs[v].mode) s += vecs[v].l[k*vecs[v].n + c] * vecs[v].w[i*vecs[v].n + k];
                    else               s += vecs[v].l[c*vecs[v].n + k] * vecs[v].w[i*vecs[v].n + k];
                vecs[v].e[i*vecs[v].n + c] = s;
            end
    endfunction

    function automatic longint rnd_word();
        if ($urandom_range(0, 1) == 0) return longint'($urandom_range(0, 200)) - 100;
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic send_w(input longint x, input bit gaps);
        int c = 0;
        bit hs = 0;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        W_IN = x; W_IN_VALID = 1'b1;
        while (!hs && c < 100) begin
            @(negedge CLK); hs = W_IN_READY; tick(); c++;
        end
        W_IN_VALID = 1'b0;
        if (!hs) chk("w_handshake_timeout", 0, 1);
    endtask

    task automatic send_l(input longint x, input bit gaps);
        int c = 0;
        bit hs = 0;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        L_IN = x; L_IN_VALID = 1'b1;
        while (!hs && c < 100) begin
            @(negedge CLK); hs = L_IN_READY; tick(); c++;
        end
        L_IN_VALID = 1'b0;
        if (!hs) chk("l_handshake_timeout", 0, 1);
    endtask

    task automatic start_op(input int r, input int n, input bit mode);
        SIZE_R_IN = DS'(r); SIZE_N_IN = DS'(n); MODE = mode; START = 1'b1;
        tick();
        START = 1'b0;
        // Later changes of the size/mode inputs must not matter.
        SIZE_R_IN = {$urandom, $urandom}; SIZE_N_IN = 0; MODE = ~mode;
    endtask

    task automatic run_vec(input int v);
        int  tot, k, cyc, lat;
        bit  held;
        longint snap;
        bit  sj, sl;
        tot = vecs[v].r * vecs[v].n;
        start_op(vecs[v].r, vecs[v].n, vecs[v].mode);
        if (vecs[v].gaps) START = 1'b1;   // must be ignored outside IDLE
        for (int x = 0; x < tot; x++) send_w(vecs[v].w[x], vecs[v].gaps);
        START = 1'b0;
        for (int x = 0; x < vecs[v].n * vecs[v].n; x++) send_l(vecs[v].l[x], vecs[v].gaps);
        lat = 0;
        do begin tick(); lat++; end while (!B_OUT_VALID && lat < 100);
        chk($sformatf("v%0d_latency", v), lat, vecs[v].r + 1);
        k = 0; cyc = 0; held = 0;
        while (k < tot && cyc < 2000) begin
            if (vecs[v].bp && k == 1 && !held) begin
                B_OUT_READY = 1'b0;
                @(negedge CLK); snap = B_OUT; sj = B_OUT_J_LAST; sl = B_OUT_LAST;
                repeat (5) begin
                    @(negedge CLK);
                    chk($sformatf("v%0d_hold_data", v), B_OUT, snap);
                    chk($sformatf("v%0d_hold_valid", v), B_OUT_VALID, 1);
                    chk($sformatf("v%0d_hold_flags", v), {sj, sl}, {B_OUT_J_LAST, B_OUT_LAST});
                end
                tick();
                held = 1;
            end
            B_OUT_READY = vecs[v].bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge CLK);
            if (B_OUT_VALID && B_OUT_READY) begin
                chk($sformatf("v%0d_out%0d", v, k), B_OUT, vecs[v].e[k]);
                chk($sformatf("v%0d_jlast%0d", v, k), B_OUT_J_LAST, (k % vecs[v].n) == vecs[v].n - 1);
                chk($sformatf("v%0d_last%0d", v, k), B_OUT_LAST, k == tot - 1);
                k++;
            end
            tick(); cyc++;
        end
        if (k < tot) chk($sformatf("v%0d_output_timeout", v), k, tot);
        B_OUT_READY = 1'b0;
        chk($sformatf("v%0d_ready_pulse", v), READY, 1);
        chk($sformatf("v%0d_valid_drop", v), B_OUT_VALID, 0);
        tick();
        chk($sformatf("v%0d_ready_once", v), READY, 0);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_b_out"}, B_OUT, 0);
        chk({nm, "_flags"}, {B_OUT_VALID, B_OUT_J_LAST, B_OUT_LAST, READY, ERROR, W_IN_READY, L_IN_READY}, 0);
    endtask

    task automatic bad_start(input string nm, input int r, input int n);
        start_op(r, n, 1'b0);
        chk({nm, "_error"}, ERROR, 1);
        chk({nm, "_no_wready"}, W_IN_READY, 0);
        tick();
        chk({nm, "_error_once"}, ERROR, 0);
        chk({nm, "_quiet"}, {W_IN_READY, L_IN_READY, READY, B_OUT_VALID}, 0);
    endtask

    initial begin
        RST = 1'b1; START = 0; MODE = 0; SIZE_R_IN = 0; SIZE_N_IN = 0;
        W_IN = 0; W_IN_VALID = 0; L_IN = 0; L_IN_VALID = 0; B_OUT_READY = 0;

        // Fixed vectors with hand-computed results.
        vecs[0].r = 1; vecs[0].n = 2; vecs[0].mode = 0; vecs[0].gaps = 0; vecs[0].bp = 0;
        vecs[0].w[0] = 5; vecs[0].w[1] = 6;
        vecs[0].l[0] = 1; vecs[0].l[1] = 2; vecs[0].l[2] = 3; vecs[0].l[3] = 4;
        vecs[0].e[0] = 23; vecs[0].e[1] = 34;
        vecs[1] = vecs[0];
        vecs[1].mode = 1; vecs[1].e[0] = 17; vecs[1].e[1] = 39;
        vecs[2].r = 2; vecs[2].n = 3; vecs[2].mode = 0; vecs[2].gaps = 0; vecs[2].bp = 1;
        for (int x = 0; x < 6; x++) begin vecs[2].w[x] = x + 1; vecs[2].e[x] = x + 1; end
        for (int x = 0; x < 9; x++) vecs[2].l[x] = (x % 4 == 0) ? 1 : 0;
        // Randomized vectors scored by the reference model.
        for (int v = 3; v < NV; v++) begin
            vecs[v].r    = (v == 3) ? 4 : $urandom_range(1, 4);
            vecs[v].n    = (v == 3) ? 8 : $urandom_range(1, 8);
            vecs[v].mode = (v == 3) ? 1'b0 : 1'(($urandom & 1));
            vecs[v].gaps = (v % 2 == 0);
            vecs[v].bp   = (v % 3 == 0) || (vecs[v].r * vecs[v].n > 1 && v == 4);
            for (int x = 0; x < 32; x++) vecs[v].w[x] = rnd_word();
            for (int x = 0; x < 64; x++) vecs[v].l[x] = rnd_word();
            fill_expect(v);
        end
        // Keep the hold sequence only where a second word exists.
        for (int v = 0; v < NV; v++) if (vecs[v].r * vecs[v].n < 2) vecs[v].bp = 0;

        tick(); tick();
        chk_idle_outputs("reset");
        RST = 1'b0;
        tick();
        chk_idle_outputs("post_reset");

        bad_start("err_n0", 1, 0);
        bad_start("err_r5", 5, 2);

        for (int v = 0; v < NV; v++) run_vec(v);

        // Reset in the middle of streaming L, then a clean rerun.
        start_op(1, 2, 1'b0);
        send_w(5, 0); send_w(6, 0);
        send_l(1, 0);
        tick();
        chk("mid_reset_in_load_l", L_IN_READY, 1);
        RST = 1'b1;
        tick();
        chk_idle_outputs("mid_reset");
        RST = 1'b0;
        tick();
        run_vec(0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
